// File: rtl/fetch_seq_if.sv
// -----------------------------------------------------------------------------
// fetch_seq_if
//   Bundles the signals around the fetch sequencer into one interface:
//   the instruction-memory req/ack port, the decode issue port and the
//   branch/jump redirect port.
//
//   Signals
//     mem_req    sequencer -> memory  read request
//     mem_addr   sequencer -> memory  16-bit word address of the request
//     mem_ack    memory -> sequencer  read data valid, completes the request
//     mem_rdata  memory -> sequencer  16-bit read data
//     dec_ready  decode -> sequencer  decode can accept an instruction
//     ins        sequencer -> decode  instruction word
//     ins_en     sequencer -> decode  one-cycle issue strobe
//     ext        sequencer -> decode  extension word (0 when none)
//     ins_pc     sequencer -> decode  word address of the issued instruction
//     redir_en   branch -> sequencer  one-cycle redirect request
//     redir_pc   branch -> sequencer  redirect target word address
//
//   master: the sequencer side.  slave: memory/decode/branch side.
// -----------------------------------------------------------------------------
interface fetch_seq_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        dec_ready;
   logic [15:0] ins;
   logic        ins_en;
   logic [15:0] ext;
   logic [15:0] ins_pc;
   logic        redir_en;
   logic [15:0] redir_pc;

   modport master (
      output mem_req, mem_addr, ins, ins_en, ext, ins_pc,
      input  mem_ack, mem_rdata, dec_ready, redir_en, redir_pc
   );

   modport slave (
      input  mem_req, mem_addr, ins, ins_en, ext, ins_pc,
      output mem_ack, mem_rdata, dec_ready, redir_en, redir_pc
   );
endinterface

// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq
//   Instruction fetch sequencer feeding the decode stage.  Reads 16-bit
//   instruction words over a req/ack memory port, fetches an extension word
//   for JMPIMM opcodes, and issues ins/ext/ins_pc to decode with a one-cycle
//   ins_en strobe.  Tracks the program counter and accepts redirects from the
//   branch/jump path, squashing any in-flight fetch.
//
//   Ports
//     cpu_clk   clock, all logic on posedge
//     cpu_rst   synchronous active-high reset
//     bus       fetch_seq_if.master (memory, decode and redirect signals)
//
//   Parameters
//     RESET_PC  word address fetched first after reset
// -----------------------------------------------------------------------------
module fetch_seq #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   fetch_seq_if.master bus
);

   // Opcode field and JMPIMM encoding, matching the shared opcode header.
   localparam logic [3:0] OPC_JMPIMM = 4'hC;

   function automatic logic is_jmpimm(input logic [15:0] word);
      return word[15:12] == OPC_JMPIMM;
   endfunction

   typedef enum logic [1:0] {
      FETCH_INS = 2'd0,
      FETCH_EXT = 2'd1,
      ISSUE     = 2'd2,
      FLUSH     = 2'd3
   } state_t;

   state_t      state_q;
   logic [15:0] pc_q;
   logic        mem_req_q;
   logic [15:0] mem_addr_q;
   logic [15:0] ins_hold_q;   // instruction waiting to issue
   logic [15:0] ext_hold_q;   // its extension word (0 when none)
   logic [15:0] ipc_hold_q;   // its word address
   logic [15:0] ins_q;
   logic [15:0] ext_q;
   logic [15:0] ins_pc_q;
   logic        ins_en_q;

   logic        ack_v;
   logic        req_pend;
   logic [15:0] pc_inc_d;

   // An ack only counts while a request is actually on the bus.
   assign ack_v    = bus.mem_ack & mem_req_q;
   // Request on the bus that is not completing this cycle; mem_req/mem_addr
   // must stay frozen for it.
   assign req_pend = mem_req_q & ~bus.mem_ack;
   assign pc_inc_d = pc_q + 16'd1;   // natural 16-bit wrap FFFF -> 0000

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q    <= FETCH_INS;
         pc_q       <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
         ins_hold_q <= 16'h0000;
         ext_hold_q <= 16'h0000;
         ipc_hold_q <= 16'h0000;
         ins_q      <= 16'h0000;
         ext_q      <= 16'h0000;
         ins_pc_q   <= 16'h0000;
         ins_en_q   <= 1'b0;
      end else begin
         ins_en_q <= 1'b0;
         if (bus.redir_en) begin
            pc_q <= bus.redir_pc;
            if (req_pend) begin
               // Let the outstanding request finish on the bus, then drop it.
               state_q <= FLUSH;
            end else begin
               // Nothing in flight (or it completes now and is discarded).
               // After an ack the request must drop for a cycle.
               state_q    <= FETCH_INS;
               mem_req_q  <= ~ack_v;
               mem_addr_q <= bus.redir_pc;
            end
         end else begin
            case (state_q)
               FETCH_INS: begin
                  if (ack_v) begin
                     ins_hold_q <= bus.mem_rdata;
                     ipc_hold_q <= pc_q;
                     pc_q       <= pc_inc_d;
                     mem_req_q  <= 1'b0;
                     mem_addr_q <= pc_inc_d;
                     if (is_jmpimm(bus.mem_rdata)) begin
                        state_q <= FETCH_EXT;
                     end else begin
                        ext_hold_q <= 16'h0000;
                        state_q    <= ISSUE;
                     end
                  end else begin
                     mem_req_q <= 1'b1;
                  end
               end
               FETCH_EXT: begin
                  if (ack_v) begin
                     ext_hold_q <= bus.mem_rdata;
                     pc_q       <= pc_inc_d;
                     mem_req_q  <= 1'b0;
                     mem_addr_q <= pc_inc_d;
                     state_q    <= ISSUE;
                  end else begin
                     mem_req_q <= 1'b1;
                  end
               end
               ISSUE: begin
                  mem_req_q <= 1'b0;
                  if (bus.dec_ready) begin
                     ins_q     <= ins_hold_q;
                     ext_q     <= ext_hold_q;
                     ins_pc_q  <= ipc_hold_q;
                     ins_en_q  <= 1'b1;
                     mem_req_q <= 1'b1;
                     state_q   <= FETCH_INS;
                  end
               end
               FLUSH: begin
                  if (ack_v) begin
                     // Squashed data is dropped; resume at the redirected pc.
                     mem_req_q  <= 1'b0;
                     mem_addr_q <= pc_q;
                     state_q    <= FETCH_INS;
                  end else begin
                     mem_req_q <= 1'b1;
                  end
               end
               default: state_q <= FETCH_INS;
            endcase
         end
      end
   end

   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.ins      = ins_q;
   assign bus.ext      = ext_q;
   assign bus.ins_pc   = ins_pc_q;
   assign bus.ins_en   = ins_en_q;

endmodule

// File: tb/tb_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq
//   Directed-vector bench for fetch_seq with RESET_PC = 16'h0010.  Each table
//   row gives the inputs for one cycle and the outputs expected during that
//   same cycle; inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_seq_if bus ();

   fetch_seq #(.RESET_PC(16'h0010)) dut (
      .cpu_clk (clk),
      .cpu_rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic [15:0] rdata;
      logic        rdy;
      logic        rdir;
      logic [15:0] rpc;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_en;
      logic [15:0] e_ins;
      logic [15:0] e_ext;
      logic [15:0] e_ipc;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic add(input logic ack, input logic [15:0] rdata, input logic rdy,
                      input logic rdir, input logic [15:0] rpc,
                      input logic e_req, input logic [15:0] e_addr, input logic e_en,
                      input logic [15:0] e_ins, input logic [15:0] e_ext,
                      input logic [15:0] e_ipc);
      vec_t v;
      v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.rdir = rdir; v.rpc = rpc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_en = e_en;
      v.e_ins = e_ins; v.e_ext = e_ext; v.e_ipc = e_ipc;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic ack, input logic [15:0] rdata,
                        input logic rdy, input logic rdir, input logic [15:0] rpc);
      rst           = r;
      bus.mem_ack   = ack;
      bus.mem_rdata = rdata;
      bus.dec_ready = rdy;
      bus.redir_en  = rdir;
      bus.redir_pc  = rpc;
   endtask

   task automatic check(input string name, input logic e_req, input logic [15:0] e_addr,
                        input logic e_en, input logic [15:0] e_ins,
                        input logic [15:0] e_ext, input logic [15:0] e_ipc);
      n_vec++;
      if (bus.mem_req !== e_req || bus.mem_addr !== e_addr || bus.ins_en !== e_en ||
          bus.ins !== e_ins || bus.ext !== e_ext || bus.ins_pc !== e_ipc) begin
         n_err++;
         $display("FAIL %s: got req=%b addr=%h en=%b ins=%h ext=%h pc=%h, want req=%b addr=%h en=%b ins=%h ext=%h pc=%h",
                  name, bus.mem_req, bus.mem_addr, bus.ins_en, bus.ins, bus.ext, bus.ins_pc,
                  e_req, e_addr, e_en, e_ins, e_ext, e_ipc);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //    ack rdata     rdy rdir rpc       req addr     en ins       ext       ipc
      // reset state; an ack with no request is ignored
      add(1, 16'h5555, 1, 0, 16'h0000,  0, 16'h0010, 0, 16'h0000, 16'h0000, 16'h0000);
      // zero-wait one-word instruction
      add(1, 16'h1234, 1, 0, 16'h0000,  1, 16'h0010, 0, 16'h0000, 16'h0000, 16'h0000);
      add(0, 16'h0000, 1, 0, 16'h0000,  0, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0000);
      add(0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0011, 1, 16'h1234, 16'h0000, 16'h0010);
      // JMPIMM with two-cycle ack delays on both words
      add(0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0011, 0, 16'h1234, 16'h0000, 16'h0010);
      add(1, 16'hC123, 1, 0, 16'h0000,  1, 16'h0011, 0, 16'h1234, 16'h0000, 16'h0010);
      add(1, 16'hDEAD, 1, 0, 16'h0000,  0, 16'h0012, 0, 16'h1234, 16'h0000, 16'h0010);
      add(0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0012, 0, 16'h1234, 16'h0000, 16'h0010);
      add(0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0012, 0, 16'h1234, 16'h0000, 16'h0010);
      add(1, 16'hBEEF, 1, 0, 16'h0000,  1, 16'h0012, 0, 16'h1234, 16'h0000, 16'h0010);
      // decode stalls for 5 cycles in ISSUE
      add(0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0013, 0, 16'h1234, 16'h0000, 16'h0010);
      add(0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0013, 0, 16'h1234, 16'h0000, 16'h0010);
      add(1, 16'h7777, 0, 0, 16'h0000,  0, 16'h0013, 0, 16'h1234, 16'h0000, 16'h0010);
      add(0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0013, 0, 16'h1234, 16'h0000, 16'h0010);
      add(0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0013, 0, 16'h1234, 16'h0000, 16'h0010);
      add(0, 16'h0000, 1, 0, 16'h0000,  0, 16'h0013, 0, 16'h1234, 16'h0000, 16'h0010);
      // strobe; redirect to 0x0040 with the ack in the same cycle
      add(1, 16'h1111, 1, 1, 16'h0040,  1, 16'h0013, 1, 16'hC123, 16'hBEEF, 16'h0011);
      add(0, 16'h0000, 1, 0, 16'h0000,  0, 16'h0040, 0, 16'hC123, 16'hBEEF, 16'h0011);
      // redirect to 0x0200 while 0x0040 is pending, ack 3 cycles later
      add(0, 16'h0000, 1, 1, 16'h0200,  1, 16'h0040, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0040, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0040, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(1, 16'hAAAA, 1, 0, 16'h0000,  1, 16'h0040, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(0, 16'h0000, 1, 0, 16'h0000,  0, 16'h0200, 0, 16'hC123, 16'hBEEF, 16'h0011);
      // fetch at 0x0200, then redirect in ISSUE drops it despite dec_ready
      add(1, 16'h2222, 1, 0, 16'h0000,  1, 16'h0200, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(0, 16'h0000, 1, 1, 16'hFFFF,  0, 16'h0201, 0, 16'hC123, 16'hBEEF, 16'h0011);
      // JMPIMM at 0xFFFF: extension comes from 0x0000
      add(1, 16'hC0DE, 1, 0, 16'h0000,  1, 16'hFFFF, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(0, 16'h0000, 1, 0, 16'h0000,  0, 16'h0000, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(1, 16'h1357, 1, 0, 16'h0000,  1, 16'h0000, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(0, 16'h0000, 1, 0, 16'h0000,  0, 16'h0001, 0, 16'hC123, 16'hBEEF, 16'h0011);
      add(0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0001, 1, 16'hC0DE, 16'h1357, 16'hFFFF);
      // two redirects while flushing; the last target wins
      add(0, 16'h0000, 1, 1, 16'h0300,  1, 16'h0001, 0, 16'hC0DE, 16'h1357, 16'hFFFF);
      add(0, 16'h0000, 1, 1, 16'h0400,  1, 16'h0001, 0, 16'hC0DE, 16'h1357, 16'hFFFF);
      add(1, 16'h9999, 1, 0, 16'h0000,  1, 16'h0001, 0, 16'hC0DE, 16'h1357, 16'hFFFF);
      add(0, 16'h0000, 1, 0, 16'h0000,  0, 16'h0400, 0, 16'hC0DE, 16'h1357, 16'hFFFF);

      drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(1'b0, vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].rdir, vecs[i].rpc);
         check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_en,
               vecs[i].e_ins, vecs[i].e_ext, vecs[i].e_ipc);
      end

      // Reset while FETCH_EXT has a request on the bus.
      @(negedge clk);
      drive(1'b0, 1'b1, 16'hC001, 1'b1, 1'b0, 16'h0000);
      check("rst_seq_ins", 1'b1, 16'h0400, 1'b0, 16'hC0DE, 16'h1357, 16'hFFFF);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      check("rst_seq_ext_gap", 1'b0, 16'h0401, 1'b0, 16'hC0DE, 16'h1357, 16'hFFFF);
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      check("rst_seq_ext_req", 1'b1, 16'h0401, 1'b0, 16'hC0DE, 16'h1357, 16'hFFFF);
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h0042, 1'b1, 1'b0, 16'h0000);
      check("rst_seq_cleared", 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      // Restart at RESET_PC with zero-wait memory: req/ack, ISSUE, strobe.
      @(negedge clk);
      check("restart_req", 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      check("restart_issue", 1'b0, 16'h0011, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      check("restart_strobe", 1'b1, 16'h0011, 1'b1, 16'h0042, 16'h0000, 16'h0010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
